// File: rtl/mem_txn_ctrl.sv
// rtl/mem_txn_ctrl.sv - queued single-port memory transaction controller
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*             request in: valid/ready handshake, op, address, write data
//   rsp_*             read response out: valid/ready handshake, address, data
//   mem_*             memory port: read/write strobes, address, write data, read data
//   busy              request FIFO non-empty or a transaction in flight
//   txn_count         completed memory accesses, wraps modulo 2^16
module mem_txn_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic [15:0]       txn_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Request FIFO
  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Transaction FSM and its registered outputs
  state_t            state_q;
  logic              op_write_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [15:0]       txn_count_q;

  assign {head_write, head_addr, head_data} = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    // Ready comes only from the registered count, so a pop in the same
    // cycle never opens a slot early.
    push       = req_valid && !fifo_full;
    // The FSM only takes a new request while idle.
    pop        = (state_q == IDLE) && !fifo_empty;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO payload storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      txn_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            op_write_q  <= head_write;
            mem_addr_q  <= head_addr;
            mem_data_q  <= head_data;
            mem_write_q <= head_write;
            mem_read_q  <= !head_write;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          // Strobes last exactly this one cycle; address/data stay parked.
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          txn_count_q <= txn_count_q + 16'd1;
          state_q     <= op_write_q ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          // Memory returns data one cycle after the read strobe.
          rsp_rdata_q <= mem_data_out;
          rsp_addr_q  <= mem_addr_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = !fifo_full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign txn_count   = txn_count_q;

endmodule

// File: tb/tb_mem_txn_ctrl.sv
// tb/tb_mem_txn_ctrl.sv - scoreboard bench for mem_txn_ctrl
module tb_mem_txn_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          busy;
  logic [15:0]   txn_count;

  mem_txn_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: synchronous read, data valid the cycle after mem_read.
  logic          mem_clr;
  logic [DW-1:0] mem_arr [32];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem_arr[i] <= '0;
    end else begin
      if (mem_write) mem_arr[mem_addr] <= mem_data_in;
      if (mem_read) mem_data_out <= mem_arr[mem_addr];
    end
  end

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } mop_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } rsp_t;

  mop_t          exp_mem[$];
  rsp_t          exp_rsp[$];
  logic [DW-1:0] shadow [32];
  int            strobe_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            acc_cyc;
  int            rsp_rise_cyc = 0;
  int            rsp_seen = 0;
  logic          rnd_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes memory or hands over a response.
  mop_t          mon_m;
  rsp_t          mon_r;
  logic          prev_strobe, prev_rv;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  initial begin
    prev_strobe = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_strobe = 1'b0;
        prev_rv = 1'b0;
      end else begin
        if (mem_read || mem_write) begin
          check("strobe_excl", mem_read & mem_write, 1'b0);
          check("strobe_1cyc", prev_strobe, 1'b0);
          strobe_cyc.push_back(cyc);
          check("sb_mem_pending", exp_mem.size() != 0, 1'b1);
          if (exp_mem.size() != 0) begin
            mon_m = exp_mem.pop_front();
            check("mem_op_write", mem_write, mon_m.wr);
            check("mem_addr", mem_addr, mon_m.addr);
            if (mon_m.wr) check("mem_data", mem_data_in, mon_m.data);
          end
        end
        if (rsp_valid) begin
          if (prev_rv) begin
            check("rsp_hold", {rsp_addr, rsp_rdata}, {held_addr, held_data});
          end else begin
            rsp_rise_cyc = cyc;
            rsp_seen++;
          end
          held_addr = rsp_addr;
          held_data = rsp_rdata;
          if (rsp_ready) begin
            check("sb_rsp_pending", exp_rsp.size() != 0, 1'b1);
            if (exp_rsp.size() != 0) begin
              mon_r = exp_rsp.pop_front();
              check("rsp_addr", rsp_addr, mon_r.addr);
              check("rsp_rdata", rsp_rdata, mon_r.data);
            end
          end
        end
        prev_rv = rsp_valid && !rsp_ready;
        prev_strobe = mem_read || mem_write;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   n;
    logic rdy;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    do begin
      @(negedge clk);
      rdy = req_ready;
      tick();
      n++;
    end while (!rdy && n < 200);
    check("req_accept", rdy, 1'b1);
    req_valid = 1'b0;
    if (rdy) begin
      acc_cyc = cyc;
      exp_mem.push_back('{wr: wr, addr: a, data: d});
      if (wr) shadow[a] = d;
      else exp_rsp.push_back('{addr: a, data: shadow[a]});
    end
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((busy || rsp_valid) && k < limit) begin
      tick();
      k++;
    end
    check("idle_reached", busy | rsp_valid, 1'b0);
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
    check("rsp_arrives", rsp_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_str, n_rsp, k;
    logic found;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; rnd_mode = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data_in, 0);
    check("rst_rsp", {rsp_valid, rsp_addr, rsp_rdata}, 0);
    check("rst_txn_count", txn_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_clr = 1'b0;
    tick();

    // Write 0x1A to addr 3, then read it back; latency from an idle block
    strobe_cyc.delete();
    send(1'b1, 5'd3, 8'h1A);
    k = acc_cyc;
    wait_idle(50);
    check("wr_strobe_latency", strobe_cyc[strobe_cyc.size()-1], k + 1);
    check("txn_after_write", txn_count, 1);
    send(1'b0, 5'd3, 8'h00);
    k = acc_cyc;
    wait_idle(50);
    check("rd_strobe_latency", strobe_cyc[strobe_cyc.size()-1], k + 1);
    check("rsp_valid_latency", rsp_rise_cyc, k + 3);
    check("txn_after_read", txn_count, 2);

    // Read addr 31 with the consumer stalled for 10 cycles
    send(1'b1, 5'd31, 8'hC5);
    rsp_ready = 1'b0;
    send(1'b0, 5'd31, 8'h00);
    wait_rsp();
    n_str = strobe_cyc.size();
    repeat (10) tick();
    check("rsp_still_valid", rsp_valid, 1'b1);
    check("no_strobe_in_resp", strobe_cyc.size(), n_str);
    rsp_ready = 1'b1;
    wait_idle(50);
    check("txn_after_stall", txn_count, 4);

    // Fill the FIFO behind a stalled response, then drain five writes
    rsp_ready = 1'b0;
    send(1'b0, 5'd3, 8'h00);
    wait_rsp();
    strobe_cyc.delete();
    send(1'b1, 5'd10, 8'h11);
    send(1'b1, 5'd11, 8'h22);
    send(1'b1, 5'd12, 8'h33);
    send(1'b1, 5'd13, 8'h44);
    @(negedge clk);
    check("full_not_ready", req_ready, 1'b0);
    tick();
    rsp_ready = 1'b1;
    send(1'b1, 5'd14, 8'h55);
    wait_idle(80);
    check("five_write_strobes", strobe_cyc.size(), 5);
    for (int i = 1; i < strobe_cyc.size(); i++) check("write_gap", strobe_cyc[i] - strobe_cyc[i-1], 2);
    check("txn_after_burst", txn_count, 10);

    // Reset during the ACCESS cycle of a read with two more queued
    rsp_ready = 1'b0;
    send(1'b0, 5'd5, 8'h00);
    wait_rsp();
    send(1'b0, 5'd3, 8'h00);
    send(1'b0, 5'd9, 8'h00);
    send(1'b0, 5'd10, 8'h00);
    tick();
    rsp_ready = 1'b1;
    found = 1'b0;
    k = 0;
    while (!found && k < 30) begin
      @(negedge clk);
      found = mem_read;
      k++;
    end
    check("reached_read_access", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {mem_read, mem_write}, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_txn_count", txn_count, 0);
    exp_mem.delete();
    exp_rsp.delete();
    tick();
    tick();
    rst_n = 1'b1;
    n_str = strobe_cyc.size();
    n_rsp = rsp_seen;
    repeat (8) tick();
    check("no_strobe_after_rst", strobe_cyc.size(), n_str);
    check("no_rsp_after_rst", rsp_seen, n_rsp);
    check("idle_after_rst", busy, 1'b0);

    // Mixed traffic over a small address window with a random consumer
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom));
    end
    wait_idle(600);
    rnd_mode = 1'b0;
    rsp_ready = 1'b1;
    check("txn_after_random", txn_count, 40);

    // Counter wrap: preload near the top, then two more writes
    dut.txn_count_q <= 16'hFFFE;
    tick();
    check("txn_preload", txn_count, 16'hFFFE);
    send(1'b1, 5'd20, 8'h77);
    wait_idle(50);
    check("txn_ffff", txn_count, 16'hFFFF);
    send(1'b1, 5'd21, 8'h78);
    wait_idle(50);
    check("txn_wrap", txn_count, 16'h0000);

    tick();
    check("sb_mem_drained", exp_mem.size(), 0);
    check("sb_rsp_drained", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
